// File: rtl/exe_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_stage_pkg
// Shared definitions for the execute stage: control-bus widths, alu_op and
// op_md bit positions, FSM state encoding, reset polarity and small helpers
// for the divider sign handling.
// -----------------------------------------------------------------------------
package exe_stage_pkg;

   localparam int DATA_W    = 32;
   localparam int ID_CTRL_W = 192;
   localparam int EX_CTRL_W = 220;
   localparam int BYPASS_W  = 38;

   // Active level of the asynchronous reset
   localparam logic REST_EN = 1'b0;

   // alu_op one-hot bit positions
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;
   localparam int ALU_MUL  = 12;
   localparam int ALU_MULH = 13;

   // op_md bit positions (bit 3 is reserved)
   localparam int MD_DIV = 0;
   localparam int MD_REM = 1;
   localparam int MD_UNS = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } ex_state_e;

   // Magnitude of a value, treating it as two's complement only when sgn=1
   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                 input logic              sgn);
      return (sgn && v[DATA_W-1]) ? -v : v;
   endfunction

   // Conditional two's-complement negation used for sign post-correction
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/exe_stage_div.sv
// -----------------------------------------------------------------------------
// exe_div
// Iterative radix-2 restoring divider, one quotient bit per step.
// Operands are converted to magnitudes on start; the sign of the quotient
// and remainder is re-applied combinationally on the result output.
//   clk, reset    : clock, asynchronous active-low reset
//   start         : latch operands and clear the step counter
//   step          : perform one shift-subtract iteration
//   dividend/divisor, is_unsigned, is_rem : operation description
//   last_step     : current step is the final one
//   result        : sign-corrected quotient or remainder
// -----------------------------------------------------------------------------
module exe_div
   import exe_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              is_unsigned,
   input  logic              is_rem,
   output logic              last_step,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic              div0_q, div0_d;
   logic              is_rem_q, is_rem_d;

   logic [DATA_W:0]   partial;
   logic [DATA_W:0]   diff;

   // Shift the next dividend bit into the partial remainder; a clear borrow
   // bit in diff means partial >= divisor.
   assign partial = {rem_q, quo_q[DATA_W-1]};
   assign diff    = partial - {1'b0, dsr_q};

   always_comb begin
      rem_d     = rem_q;
      quo_d     = quo_q;
      dsr_d     = dsr_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      is_rem_d  = is_rem_q;
      if (start) begin
         rem_d     = '0;
         quo_d     = abs_val(dividend, ~is_unsigned);
         dsr_d     = abs_val(divisor, ~is_unsigned);
         cnt_d     = '0;
         neg_quo_d = ~is_unsigned & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
         neg_rem_d = ~is_unsigned & dividend[DATA_W-1];
         div0_d    = (divisor == '0);
         is_rem_d  = is_rem;
      end else if (step) begin
         if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
         end else begin
            rem_d = partial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == REST_EN) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         is_rem_q  <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dsr_q     <= dsr_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         is_rem_q  <= is_rem_d;
      end
   end

   assign last_step = (cnt_q == CNT_W'(DIV_CYCLES - 1));

   // A zero divisor leaves |dividend| in the remainder, so the sign-corrected
   // remainder already equals src1; only the quotient needs forcing.
   always_comb begin
      if (is_rem_q)
         result = cond_neg(rem_q, neg_rem_q);
      else if (div0_q)
         result = '1;
      else
         result = cond_neg(quo_q, neg_quo_q);
   end

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage: single-cycle ALU/multiply, iterative divide via exe_div,
// registered MEM-facing control bus under valid/ready handshakes, and the
// EX forwarding bypass.
//   clk, reset        : clock, asynchronous active-low reset
//   id_ctrl_bus       : decoded control bus from ID (held while left_ready=0)
//   left_valid/ready  : ID -> EX handshake
//   mem_ctrl_bus      : registered control bus plus alu_result to MEM
//   right_valid/ready : EX -> MEM handshake
//   ex_bypass         : {result, wreg_index, wreg_en} of the current input
//   ex_is_load        : load-use hazard indication to ID
// -----------------------------------------------------------------------------
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ID_CTRL_W-1:0] id_ctrl_bus,
   output logic [EX_CTRL_W-1:0] mem_ctrl_bus,
   output logic [BYPASS_W-1:0]  ex_bypass,
   output logic                 ex_is_load,
   input  logic                 left_valid,
   output logic                 left_ready,
   output logic                 right_valid,
   input  logic                 right_ready
);

   logic [2:0]         op_md;
   logic [5:0]         op_mem;
   logic [13:0]        alu_op;
   logic               inst_valid;
   logic [4:0]         wreg_index;
   logic               wreg_en;
   logic [DATA_W-1:0]  src1, src2;
   logic               md_rsvd_unused;

   assign op_md          = id_ctrl_bus[190:188];
   assign md_rsvd_unused = id_ctrl_bus[191];
   assign op_mem         = id_ctrl_bus[186:181];
   assign alu_op         = id_ctrl_bus[180:167];
   assign inst_valid     = id_ctrl_bus[166];
   assign wreg_index     = id_ctrl_bus[69:65];
   assign wreg_en        = id_ctrl_bus[64];
   assign src2           = id_ctrl_bus[63:32];
   assign src1           = id_ctrl_bus[31:0];

   // ---- ALU (combinational on the current ID input) ----
   logic signed [DATA_W-1:0]   src1_s, src2_s;
   logic signed [2*DATA_W-1:0] prod;
   logic [4:0]                 shamt;
   logic [DATA_W-1:0]          alu_result;

   assign src1_s = src1;
   assign src2_s = src2;
   assign prod   = src1_s * src2_s;
   assign shamt  = src2[4:0];

   always_comb begin
      alu_result = '0;
      if (alu_op[ALU_ADD])  alu_result |= src1 + src2;
      if (alu_op[ALU_SUB])  alu_result |= src1 - src2;
      if (alu_op[ALU_SLT])  alu_result |= {{(DATA_W-1){1'b0}}, (src1_s < src2_s)};
      if (alu_op[ALU_SLTU]) alu_result |= {{(DATA_W-1){1'b0}}, (src1 < src2)};
      if (alu_op[ALU_AND])  alu_result |= src1 & src2;
      if (alu_op[ALU_NOR])  alu_result |= ~(src1 | src2);
      if (alu_op[ALU_OR])   alu_result |= src1 | src2;
      if (alu_op[ALU_XOR])  alu_result |= src1 ^ src2;
      if (alu_op[ALU_SLL])  alu_result |= src1 << shamt;
      if (alu_op[ALU_SRL])  alu_result |= src1 >> shamt;
      if (alu_op[ALU_SRA])  alu_result |= DATA_W'(src1_s >>> shamt);
      if (alu_op[ALU_LUI])  alu_result |= src2;
      if (alu_op[ALU_MUL])  alu_result |= prod[DATA_W-1:0];
      if (alu_op[ALU_MULH]) alu_result |= prod[2*DATA_W-1:DATA_W];
   end

   // ---- Divide control FSM ----
   ex_state_e         state_q, state_d;
   logic              is_div;
   logic              div_start, div_step, div_last;
   logic              accept;
   logic [DATA_W-1:0] div_result;

   // A divide with inst_valid=0 is a bubble and goes down the ALU path
   assign is_div = op_md[MD_DIV] & inst_valid;
   assign accept = left_valid & left_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (reset == REST_EN) state_q <= ST_IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (left_valid && is_div) state_d = ST_BUSY;
         ST_BUSY: if (div_last)             state_d = ST_DONE;
         ST_DONE: if (accept)               state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      left_ready = 1'b0;
      div_start  = 1'b0;
      div_step   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (left_valid && is_div) div_start  = 1'b1;
            else                      left_ready = right_ready;
         end
         ST_BUSY: div_step   = 1'b1;
         ST_DONE: left_ready = right_ready;
         default: ;
      endcase
   end

   exe_div #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .start       (div_start),
      .step        (div_step),
      .dividend    (src1),
      .divisor     (src2),
      .is_unsigned (op_md[MD_UNS]),
      .is_rem      (op_md[MD_REM]),
      .last_step   (div_last),
      .result      (div_result)
   );

   // ---- EX -> MEM output register ----
   logic                 right_valid_q, right_valid_d;
   logic [EX_CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;

   always_comb begin
      right_valid_d = right_valid_q;
      mem_ctrl_d    = mem_ctrl_q;
      if (accept) begin
         right_valid_d = 1'b1;
         // op_md is dropped; everything below it passes straight through
         mem_ctrl_d    = {id_ctrl_bus[187:0],
                          (state_q == ST_DONE) ? div_result : alu_result};
      end else if (right_ready) begin
         right_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == REST_EN) begin
         right_valid_q <= 1'b0;
         mem_ctrl_q    <= '0;
      end else begin
         right_valid_q <= right_valid_d;
         mem_ctrl_q    <= mem_ctrl_d;
      end
   end

   assign right_valid  = right_valid_q;
   assign mem_ctrl_bus = mem_ctrl_q;

   // Forwarding is suppressed while a divide is in flight
   assign ex_bypass  = {alu_result, wreg_index, wreg_en & (state_q == ST_IDLE)};
   assign ex_is_load = op_mem[0] & ~op_mem[2] & left_valid;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

   logic         clk;
   logic         reset;
   logic [191:0] id_ctrl_bus;
   logic [219:0] mem_ctrl_bus;
   logic [37:0]  ex_bypass;
   logic         ex_is_load;
   logic         left_valid;
   logic         left_ready;
   logic         right_valid;
   logic         right_ready;

   exe_stage #(.DIV_CYCLES(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_ctrl_bus  (id_ctrl_bus),
      .mem_ctrl_bus (mem_ctrl_bus),
      .ex_bypass    (ex_bypass),
      .ex_is_load   (ex_is_load),
      .left_valid   (left_valid),
      .left_ready   (left_ready),
      .right_valid  (right_valid),
      .right_ready  (right_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        nm;
      logic [219:0] bus;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [219:0] act, input logic [219:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [13:0] oh(input int i);
      logic [13:0] one;
      one = 14'd1;
      return one << i;
   endfunction

   function automatic logic [191:0] mk_bus(input logic [3:0] md, input logic [5:0] mem,
                                           input logic [13:0] alu, input logic iv,
                                           input logic [4:0] widx, input logic wen,
                                           input logic [31:0] s1, input logic [31:0] s2);
      return {md, 1'b0, mem, alu, iv, 32'h0000_0ABC, 32'h0040_1000, 32'hDEAD_BEEF,
              widx, wen, s2, s1};
   endfunction

   // Scoreboard monitor: every handshake on the MEM side pops one expectation
   always @(negedge clk) begin
      if (reset && right_valid && right_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %h expected none", mem_ctrl_bus);
         end else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.nm, mem_ctrl_bus, mon_e.bus);
         end
      end
   end

   task automatic issue_alu(input string nm, input logic [13:0] alu, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] exp,
                            input logic [3:0] md = 4'd0, input logic iv = 1'b1);
      logic [191:0] b;
      @(posedge clk); #1;
      b           = mk_bus(md, 6'd0, alu, iv, 5'd3, 1'b1, s1, s2);
      id_ctrl_bus = b;
      left_valid  = 1'b1;
      right_ready = 1'b1;
      exp_q.push_back('{nm, {b[187:0], exp}});
      #1;
      chk({nm, "_bypass"}, 220'(ex_bypass), 220'({exp, 5'd3, 1'b1}));
      @(negedge clk);
      chk({nm, "_left_ready"}, 220'(left_ready), 220'(1));
      @(posedge clk); #1;
      left_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_latency"}, 220'(right_valid), 220'(1));
   endtask

   task automatic issue_div(input string nm, input logic [3:0] md, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] exp, input int bp_hold);
      logic [191:0] b;
      int           cnt;
      bit           got;
      @(posedge clk); #1;
      b           = mk_bus(md, 6'd0, 14'd0, 1'b1, 5'd7, 1'b1, s1, s2);
      id_ctrl_bus = b;
      left_valid  = 1'b1;
      right_ready = (bp_hold == 0);
      exp_q.push_back('{nm, {b[187:0], exp}});
      cnt = 0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 1) chk({nm, "_busy_no_fwd"}, 220'(ex_bypass[0]), 220'(0));
         if (left_ready) begin
            got = 1'b1;
            break;
         end
         cnt++;
         if (bp_hold > 0 && cnt == 33 + bp_hold) begin
            chk({nm, "_held_no_valid"}, 220'(right_valid), 220'(0));
            @(posedge clk); #1;
            right_ready = 1'b1;
         end
      end
      chk({nm, "_accept_seen"}, 220'(got), 220'(1));
      chk({nm, "_stall_cycles"}, 220'(cnt), 220'(33 + bp_hold));
      @(posedge clk); #1;
      left_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_valid_rise"}, 220'(right_valid), 220'(1));
      @(negedge clk);
      chk({nm, "_single_accept"}, 220'(right_valid), 220'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      left_valid  = 1'b0;
      right_ready = 1'b0;
      id_ctrl_bus = '0;
      #12;
      chk("reset_right_valid", 220'(right_valid), 220'(0));
      chk("reset_mem_bus", mem_ctrl_bus, 220'(0));
      @(negedge clk);
      reset = 1'b1;

      // ALU operations
      issue_alu("add",   oh(0),  32'd5,         32'hFFFF_FFFD, 32'd2);
      issue_alu("sub",   oh(1),  32'd5,         32'hFFFF_FFFD, 32'd8);
      issue_alu("slt",   oh(2),  32'hFFFF_FFFF, 32'd1,         32'd1);
      issue_alu("sltu",  oh(3),  32'hFFFF_FFFF, 32'd1,         32'd0);
      issue_alu("and",   oh(4),  32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
      issue_alu("nor",   oh(5),  32'hF0F0_0000, 32'h0F00_00FF, 32'h000F_FF00);
      issue_alu("or",    oh(6),  32'h1200_0034, 32'h0056_7800, 32'h1256_7834);
      issue_alu("xor",   oh(7),  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
      issue_alu("sll",   oh(8),  32'd1,         32'h0000_0023, 32'd8);
      issue_alu("srl",   oh(9),  32'h8000_0000, 32'd4,         32'h0800_0000);
      issue_alu("sra",   oh(10), 32'h8000_0000, 32'd4,         32'hF800_0000);
      issue_alu("lui",   oh(11), 32'd0,         32'h1234_0000, 32'h1234_0000);
      issue_alu("mul",   oh(12), 32'h4000_0000, 32'd8,         32'd0);
      issue_alu("mulh",  oh(13), 32'h4000_0000, 32'd8,         32'd2);
      issue_alu("mul_neg",  oh(12), 32'hFFFF_FFFE, 32'd3,      32'hFFFF_FFFA);
      issue_alu("mulh_neg", oh(13), 32'hFFFF_FFFE, 32'd3,      32'hFFFF_FFFF);
      issue_alu("no_op", 14'd0,  32'h1111_1111, 32'h2222_2222, 32'd0);
      issue_alu("div_bubble", oh(0), 32'd1, 32'd1, 32'd2, 4'b0001, 1'b0);

      // Load-use hazard output
      @(posedge clk); #1;
      id_ctrl_bus = mk_bus(4'd0, 6'b000001, oh(0), 1'b1, 5'd1, 1'b1, 32'd0, 32'd0);
      left_valid  = 1'b1;
      #1 chk("is_load_lw", 220'(ex_is_load), 220'(1));
      id_ctrl_bus = mk_bus(4'd0, 6'b000101, oh(0), 1'b1, 5'd1, 1'b1, 32'd0, 32'd0);
      #1 chk("is_load_store", 220'(ex_is_load), 220'(0));
      id_ctrl_bus = mk_bus(4'd0, 6'b000001, oh(0), 1'b1, 5'd1, 1'b1, 32'd0, 32'd0);
      left_valid  = 1'b0;
      #1 chk("is_load_novalid", 220'(ex_is_load), 220'(0));
      @(negedge clk);

      // Divider
      issue_div("div_s",      4'b0001, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
      issue_div("rem_s",      4'b0011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
      issue_div("div_u",      4'b0101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 0);
      issue_div("div0_q",     4'b0001, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 0);
      issue_div("div0_r",     4'b0011, 32'h0000_1234, 32'd0,         32'h0000_1234, 0);
      issue_div("div0_r_neg", 4'b0011, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0);
      issue_div("ovf_q",      4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      issue_div("ovf_r",      4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
      issue_div("div_bp",     4'b0001, 32'd100,       32'd7,         32'd14,        10);
      issue_alu("add_after_bp", oh(0), 32'd40, 32'd2, 32'd42);

      // Reset in the middle of a divide
      @(posedge clk); #1;
      id_ctrl_bus = mk_bus(4'b0001, 6'd0, 14'd0, 1'b1, 5'd7, 1'b1, 32'd100, 32'd7);
      left_valid  = 1'b1;
      right_ready = 1'b1;
      repeat (16) @(posedge clk);
      #2;
      left_valid = 1'b0;
      reset      = 1'b0;
      #1;
      chk("midreset_right_valid", 220'(right_valid), 220'(0));
      chk("midreset_mem_bus", mem_ctrl_bus, 220'(0));
      chk("midreset_idle_ready", 220'(left_ready), 220'(1));
      @(negedge clk);
      reset = 1'b1;
      issue_alu("add_after_reset", oh(0), 32'd5, 32'hFFFF_FFFD, 32'd2);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 220'(exp_q.size()), 220'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
